// File: rtl/wb_arbiter_if.sv
// wb_arbiter_if: bus bundle between result producers, the writeback arbiter
// and the register-file writeback ports.
//   master : producer/flush side (drives i_*, observes o_ready and o_wb_*)
//   slave  : the arbiter (observes i_*, drives o_ready and o_wb_*)
// Field widths follow `NUM_PR (physical registers) and `AL_SIZE (active list);
// defaults are supplied here when the core build does not define them.
`ifndef NUM_PR
`define NUM_PR 64
`endif
`ifndef AL_SIZE
`define AL_SIZE 32
`endif

interface wb_arbiter_if #(parameter int NUM_SRC = 6);
  localparam int RD_W = $clog2(`NUM_PR);
  localparam int AL_W = $clog2(`AL_SIZE);

  logic [NUM_SRC-1:0]           i_valid;
  logic [NUM_SRC-1:0]           i_uses_rd;
  logic [NUM_SRC-1:0][RD_W-1:0] i_rd;
  logic [NUM_SRC-1:0][31:0]     i_data;
  logic [NUM_SRC-1:0][AL_W-1:0] i_al_addr;
  logic [NUM_SRC-1:0]           o_ready;
  logic                         i_flush;

  logic [3:0]                   o_wb_valid;
  logic [3:0]                   o_wb_uses_rd;
  logic [3:0][RD_W-1:0]         o_wb_rd;
  logic [3:0][31:0]             o_wb_data;
  logic [3:0][AL_W-1:0]         o_wb_al_addr;

  modport master (
    output i_valid, i_uses_rd, i_rd, i_data, i_al_addr, i_flush,
    input  o_ready, o_wb_valid, o_wb_uses_rd, o_wb_rd, o_wb_data, o_wb_al_addr
  );

  modport slave (
    input  i_valid, i_uses_rd, i_rd, i_data, i_al_addr, i_flush,
    output o_ready, o_wb_valid, o_wb_uses_rd, o_wb_rd, o_wb_data, o_wb_al_addr
  );
endinterface

// File: rtl/wb_arbiter.sv
// wb_arbiter: writeback arbiter. Buffers results from NUM_SRC producers in
// per-source FIFOs and issues up to four per cycle, round-robin, onto the
// four register-file writeback ports. Outputs are registered.
// Ports:
//   clk    : core clock, rising edge
//   reset  : synchronous, active-low
//   bus    : wb_arbiter_if.slave (producer handshake, flush, writeback ports)
//   o_stat_grants / o_stat_backpressure : 32-bit saturating counters, present
//            only when WB_ARB_STATS_EN is defined
`ifndef NUM_PR
`define NUM_PR 64
`endif
`ifndef AL_SIZE
`define AL_SIZE 32
`endif

// Per-source FIFO. `avail` counts only entries pushed at least one edge ago,
// so a result accepted at edge N is first grantable in the cycle after N+1,
// giving the two-cycle push-to-writeback latency.
module wb_arb_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         ready,
  output logic         avail
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, vis;
  logic          wr_en;

  assign ready = (count != CW'(DEPTH));
  assign avail = (vis != '0);
  assign dout  = mem[rd_ptr];
  assign wr_en = push & reset & ~flush;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      count  <= '0;
      vis    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
      // Everything held before this edge becomes grantable; this edge's push waits.
      vis   <= count - CW'(pop);
    end
  end
endmodule

module wb_arbiter #(
  parameter int NUM_SRC = 6,
  parameter int DEPTH   = 2
) (
  input  logic        clk,
  input  logic        reset,
  wb_arbiter_if.slave bus
`ifdef WB_ARB_STATS_EN
  ,
  output logic [31:0] o_stat_grants,
  output logic [31:0] o_stat_backpressure
`endif
);
  localparam int RD_W = $clog2(`NUM_PR);
  localparam int AL_W = $clog2(`AL_SIZE);
  localparam int SW   = $clog2(NUM_SRC);

  typedef struct packed {
    logic            uses_rd;
    logic [RD_W-1:0] rd;
    logic [31:0]     data;
    logic [AL_W-1:0] al_addr;
  } ent_t;

  ent_t [NUM_SRC-1:0] din, dout;
  logic [NUM_SRC-1:0] push, grant, avail, ready;

  assign bus.o_ready = ready;
  assign push        = bus.i_valid & ready;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    assign din[g] = '{uses_rd: bus.i_uses_rd[g], rd: bus.i_rd[g],
                      data: bus.i_data[g], al_addr: bus.i_al_addr[g]};
    wb_arb_fifo #(.W($bits(ent_t)), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .flush (bus.i_flush),
      .push  (push[g]),
      .pop   (grant[g]),
      .din   (din[g]),
      .dout  (dout[g]),
      .ready (ready[g]),
      .avail (avail[g])
    );
  end

  // Round-robin scan from rr_ptr; first four available sources map to ports 0..3.
  logic [SW-1:0]      rr_ptr, rr_next;
  logic [3:0]         port_vld;
  logic [3:0][SW-1:0] port_src;
  logic [2:0]         n_grant;

  always_comb begin
    int          idx;
    logic [SW-1:0] si;
    grant    = '0;
    port_vld = '0;
    port_src = '0;
    n_grant  = '0;
    rr_next  = rr_ptr;
    idx      = 0;
    si       = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_SRC) idx = idx - NUM_SRC;
      si = SW'(idx);
      if (avail[si] && n_grant < 3'd4) begin
        grant[si]              = 1'b1;
        port_vld[n_grant[1:0]] = 1'b1;
        port_src[n_grant[1:0]] = si;
        n_grant                = n_grant + 3'd1;
        rr_next                = (idx == NUM_SRC - 1) ? '0 : SW'(idx + 1);
      end
    end
  end

  logic [3:0]           wb_valid, wb_uses_rd;
  logic [3:0][RD_W-1:0] wb_rd;
  logic [3:0][31:0]     wb_data;
  logic [3:0][AL_W-1:0] wb_al_addr;

  always_ff @(posedge clk) begin
    if (!reset) begin
      rr_ptr     <= '0;
      wb_valid   <= '0;
      wb_uses_rd <= '0;
      wb_rd      <= '0;
      wb_data    <= '0;
      wb_al_addr <= '0;
    end else if (bus.i_flush) begin
      // Drop whatever was granted this cycle; round-robin position survives.
      wb_valid <= '0;
    end else begin
      rr_ptr   <= rr_next;
      wb_valid <= port_vld;
      for (int k = 0; k < 4; k++) begin
        if (port_vld[k]) begin
          wb_uses_rd[k] <= dout[port_src[k]].uses_rd;
          wb_rd[k]      <= dout[port_src[k]].rd;
          wb_data[k]    <= dout[port_src[k]].data;
          wb_al_addr[k] <= dout[port_src[k]].al_addr;
        end
      end
    end
  end

  assign bus.o_wb_valid   = wb_valid;
  assign bus.o_wb_uses_rd = wb_uses_rd;
  assign bus.o_wb_rd      = wb_rd;
  assign bus.o_wb_data    = wb_data;
  assign bus.o_wb_al_addr = wb_al_addr;

`ifdef WB_ARB_STATS_EN
  logic [32:0] grant_sum;
  assign grant_sum = {1'b0, o_stat_grants} + 33'(n_grant);

  always_ff @(posedge clk) begin
    if (!reset) begin
      o_stat_grants       <= '0;
      o_stat_backpressure <= '0;
    end else begin
      // Grants discarded by a flush are not counted.
      if (!bus.i_flush)
        o_stat_grants <= grant_sum[32] ? '1 : grant_sum[31:0];
      if (|(bus.i_valid & ~ready) && o_stat_backpressure != '1)
        o_stat_backpressure <= o_stat_backpressure + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_wb_arbiter.sv
`ifndef NUM_PR
`define NUM_PR 64
`endif
`ifndef AL_SIZE
`define AL_SIZE 32
`endif

module tb_wb_arbiter;
  localparam int NS    = 6;
  localparam int DEPTH = 2;
  localparam int RD_W  = $clog2(`NUM_PR);
  localparam int AL_W  = $clog2(`AL_SIZE);

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  wb_arbiter_if #(.NUM_SRC(NS)) bus ();

`ifdef WB_ARB_STATS_EN
  logic [31:0] stat_grants, stat_bp;
`endif

  wb_arbiter #(.NUM_SRC(NS), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
`ifdef WB_ARB_STATS_EN
    ,
    .o_stat_grants       (stat_grants),
    .o_stat_backpressure (stat_bp)
`endif
  );

  typedef struct {
    bit              u;
    logic [RD_W-1:0] rd;
    logic [31:0]     data;
    logic [AL_W-1:0] al;
    int              stamp;   // cycle in which the source pushed it
  } ent_t;

  typedef struct {
    logic [3:0]      v;
    logic [3:0]      u;
    logic [RD_W-1:0] rd   [4];
    logic [31:0]     data [4];
    logic [AL_W-1:0] al   [4];
    bit              all;     // reset edge: every field must read zero
  } exp_t;

  ent_t mq [NS][$];
  exp_t sbq [$];
  exp_t me;
  int total = 0, bad = 0, cyc = 0, rr = 0;
  longint m_grants = 0, m_bp = 0;

  logic [NS-1:0]           sv_v, sv_u;
  logic [NS-1:0][RD_W-1:0] sv_rd;
  logic [NS-1:0][31:0]     sv_data;
  logic [NS-1:0][AL_W-1:0] sv_al;
  logic                    sv_fl, sv_rst;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic clr();
    sv_v = '0; sv_u = '0; sv_rd = '0; sv_data = '0; sv_al = '0;
    sv_fl = 1'b0; sv_rst = 1'b1;
  endtask

  // One clock cycle: check o_ready against the model, drive inputs, advance
  // the reference model and queue the writeback expected after this edge.
  task automatic step();
    exp_t e;
    logic [NS-1:0] rdy;
    int ng, idx, last;
    for (int s = 0; s < NS; s++) rdy[s] = (mq[s].size() < DEPTH);
    if (cyc > 0) chk("o_ready", 64'(bus.o_ready), 64'(rdy));
    bus.i_valid = sv_v; bus.i_uses_rd = sv_u; bus.i_rd = sv_rd;
    bus.i_data = sv_data; bus.i_al_addr = sv_al; bus.i_flush = sv_fl;
    reset = sv_rst;
    e.v = '0; e.u = '0; e.all = 1'b0;
    for (int k = 0; k < 4; k++) begin e.rd[k] = '0; e.data[k] = '0; e.al[k] = '0; end
    if (!sv_rst) begin
      for (int s = 0; s < NS; s++) mq[s].delete();
      rr = 0; m_grants = 0; m_bp = 0; e.all = 1'b1;
    end else begin
      if (|(sv_v & ~rdy)) m_bp++;
      if (sv_fl) begin
        for (int s = 0; s < NS; s++) mq[s].delete();
      end else begin
        ng = 0; last = 0;
        for (int i = 0; i < NS; i++) begin
          idx = (rr + i) % NS;
          if (ng < 4 && mq[idx].size() > 0 && mq[idx][0].stamp <= cyc - 2) begin
            e.v[ng[1:0]]  = 1'b1;
            e.u[ng[1:0]]  = mq[idx][0].u;
            e.rd[ng]      = mq[idx][0].rd;
            e.data[ng]    = mq[idx][0].data;
            e.al[ng]      = mq[idx][0].al;
            void'(mq[idx].pop_front());
            ng++; last = idx;
          end
        end
        if (ng > 0) rr = (last + 1) % NS;
        m_grants += ng;
        for (int s = 0; s < NS; s++)
          if (sv_v[s] && rdy[s])
            mq[s].push_back('{u: sv_u[s], rd: sv_rd[s], data: sv_data[s], al: sv_al[s], stamp: cyc});
      end
    end
    sbq.push_back(e);
    cyc++;
    @(negedge clk);
  endtask

  // Monitor: one expected writeback set per edge, compared just after it.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        me = sbq.pop_front();
        chk("wb_valid", 64'(bus.o_wb_valid), 64'(me.v));
        for (int k = 0; k < 4; k++) begin
          if (me.v[k] || me.all) begin
            chk($sformatf("wb_uses_rd[%0d]", k), 64'(bus.o_wb_uses_rd[k]), 64'(me.u[k]));
            chk($sformatf("wb_rd[%0d]", k), 64'(bus.o_wb_rd[k]), 64'(me.rd[k]));
            chk($sformatf("wb_data[%0d]", k), 64'(bus.o_wb_data[k]), 64'(me.data[k]));
            chk($sformatf("wb_al[%0d]", k), 64'(bus.o_wb_al_addr[k]), 64'(me.al[k]));
          end
        end
      end
    end
  end

  initial begin
    clr();
    sv_rst = 1'b0;
    reset = 1'b0;
    bus.i_valid = '0; bus.i_uses_rd = '0; bus.i_rd = '0;
    bus.i_data = '0; bus.i_al_addr = '0; bus.i_flush = 1'b0;
    @(negedge clk);

    // Reset: two low edges, then check state in the following cycle.
    step(); step();
    chk("rst_wb_valid", 64'(bus.o_wb_valid), 64'(4'b0000));
    chk("rst_ready", 64'(bus.o_ready), 64'({NS{1'b1}}));

    // Single result from source 2: two-cycle latency onto port 0.
    clr();
    sv_v[2] = 1'b1; sv_u[2] = 1'b1; sv_rd[2] = RD_W'(5); sv_data[2] = 32'hDEADBEEF; sv_al[2] = AL_W'(3);
    step(); clr(); step(); step();
    chk("single_valid", 64'(bus.o_wb_valid), 64'(4'b0001));
    chk("single_rd", 64'(bus.o_wb_rd[0]), 64'(5));
    chk("single_data", 64'(bus.o_wb_data[0]), 64'(32'hDEADBEEF));

    // All six push with rr_ptr back at 0: 0..3 then 4,5 with wrap.
    clr(); sv_rst = 1'b0; step(); step();
    clr();
    sv_v = '1;
    for (int s = 0; s < NS; s++) sv_data[s] = 32'(100 + s);
    step(); clr(); step(); step();
    chk("all6_first_valid", 64'(bus.o_wb_valid), 64'(4'b1111));
    for (int k = 0; k < 4; k++) chk($sformatf("all6_first_data[%0d]", k), 64'(bus.o_wb_data[k]), 64'(100 + k));
    step();
    chk("all6_second_valid", 64'(bus.o_wb_valid), 64'(4'b0011));
    chk("all6_wrap_data0", 64'(bus.o_wb_data[0]), 64'(104));
    chk("all6_wrap_data1", 64'(bus.o_wb_data[1]), 64'(105));
    step();

    // Backpressure on source 0 under full load from all sources.
    clr(); sv_v = '1;
    for (int s = 0; s < NS; s++) sv_data[s] = 32'(200 + s);
    step(); step();
    chk("bp_ready0", 64'(bus.o_ready[0]), 64'(0));
    step(); step();
    clr(); repeat (4) step();

    // Flush with full FIFOs: nothing stale may come out afterwards.
    clr(); sv_v = '1;
    for (int s = 0; s < NS; s++) sv_data[s] = 32'(300 + s);
    step(); step(); step();
    clr(); sv_fl = 1'b1; step();
    chk("flush_valid", 64'(bus.o_wb_valid), 64'(4'b0000));
    chk("flush_ready", 64'(bus.o_ready), 64'({NS{1'b1}}));
    clr(); repeat (3) step();

    // uses_rd=0 still forwarded with its active-list index.
    clr(); sv_v[4] = 1'b1; sv_u[4] = 1'b0; sv_rd[4] = RD_W'(9); sv_al[4] = AL_W'(7);
    step(); clr(); step(); step();
    chk("nord_valid", 64'(bus.o_wb_valid), 64'(4'b0001));
    chk("nord_uses_rd", 64'(bus.o_wb_uses_rd[0]), 64'(0));
    chk("nord_al", 64'(bus.o_wb_al_addr[0]), 64'(7));

    // Randomized traffic with occasional flush and mid-operation reset.
    for (int n = 0; n < 3000; n++) begin
      clr();
      sv_v = NS'($urandom);
      if ($urandom_range(0, 3) == 0) sv_v = sv_v & NS'($urandom);
      sv_u = NS'($urandom);
      for (int s = 0; s < NS; s++) begin
        sv_rd[s] = RD_W'($urandom); sv_data[s] = $urandom; sv_al[s] = AL_W'($urandom);
      end
      sv_fl  = ($urandom_range(0, 49) == 0);
      sv_rst = !($urandom_range(0, 199) == 0);
      step();
    end

    clr(); repeat (8) step();
    for (int i = 0; i < 10 && sbq.size() > 0; i++) @(negedge clk);
    chk("scoreboard_drained", 64'(sbq.size()), 64'(0));
`ifdef WB_ARB_STATS_EN
    chk("stat_grants", 64'(stat_grants), 64'(m_grants));
    chk("stat_backpressure", 64'(stat_bp), 64'(m_bp));
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
